vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter CLK_DIV, 4, system clocks per pixel; legal values are 2..16.
REQ-002 Parameter H_VISIBLE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal segment lengths in pixels.
REQ-003 Parameter V_VISIBLE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical segment lengths in lines.
REQ-004 clk  in  1  system clock; one clock domain; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
REQ-006 rgb_in  in  8  pixel colour from the renderer, for the current x,y.
REQ-007 x  out  11  current pixel column counter, 0..H_TOTAL-1 (H_TOTAL = sum of H segments, 800).
REQ-008 y  out  11  current line counter, 0..V_TOTAL-1 (V_TOTAL = sum of V segments, 525).
REQ-009 pixel_tick  out  1  one-clk strobe marking a pixel boundary.
REQ-010 hsync, vsync  out  1 each  active-low sync pulses to the connector.
REQ-011 video_on  out  1  high while the displayed pixel is in the visible area.
REQ-012 rgb_out  out  8  colour to the DAC; 0 during blanking.
REQ-013 frame_start  out  1  one-clk pulse when x and y both wrap to 0.

Function
REQ-014 A divider counter SHALL count 0..CLK_DIV-1; pixel_tick=1 on the clk where it equals CLK_DIV-1.
REQ-015 On each pixel_tick, x SHALL increment; at x=H_TOTAL-1 it SHALL wrap to 0 and y SHALL increment.
REQ-016 y SHALL wrap from V_TOTAL-1 to 0 on the same tick as the x wrap; frame_start SHALL pulse on that clk.
REQ-017 x and y SHALL hold their value for CLK_DIV clks between ticks; the renderer has CLK_DIV-1 clks to present rgb_in.
REQ-018 On each pixel_tick, decode of the pre-increment x,y SHALL be registered: hsync=0 iff H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-019 Likewise vsync=0 iff V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC (490..491).
REQ-020 Likewise video_on=1 iff x<H_VISIBLE and y<V_VISIBLE; rgb_out = video_on-decode ? rgb_in : 8'h00.
REQ-021 hsync, vsync, video_on and rgb_out SHALL therefore be mutually aligned and lag x,y by exactly one pixel period.
REQ-022 Between ticks, hsync, vsync, video_on and rgb_out SHALL hold.
REQ-023 Counter arithmetic SHALL be unsigned 11-bit; no value outside 0..TOTAL-1 SHALL ever appear on x or y.

Reset
REQ-024 While reset=0: divider=0, x=0, y=0, pixel_tick=0, frame_start=0, hsync=1, vsync=1, video_on=0, rgb_out=0.
REQ-025 Reset asserted mid-frame SHALL clear state asynchronously, without waiting for clk or a tick.
REQ-026 After reset release, the first pixel_tick SHALL occur on the CLK_DIV-th rising clk edge.

Configuration
REQ-027 Macro VGA_TIMING_TESTPAT_EN defined: input pattern_en (1 bit) SHALL exist; when pattern_en=1, rgb_in is ignored.
REQ-028 With pattern_en=1, visible rgb_out SHALL be bar colour index x[8:6], mapped to {00,03,1C,1F,E0,E3,FC,FF}.
REQ-029 Macro undefined: pattern_en port and pattern logic SHALL be absent; rgb_in is always used.

Verification
REQ-030 Release reset, CLK_DIV=4 -> pixel_tick first at clk 4, then every 4 clks; x goes 0->1 on that tick.
REQ-031 Run one line -> hsync low for exactly 96 ticks, starting on the tick where x=656; line period is 3200 clks.
REQ-032 Run one frame -> vsync low for 2 lines (y=490,491); frame_start pulses once every 525*800 ticks.
REQ-033 rgb_in=8'hDD constant -> rgb_out=DD at x<640, y<480 (one pixel late); rgb_out=00 at x=700 and at y=500.
REQ-034 Assert reset at x=300, y=200 mid-divider -> all outputs return to REQ-024 values within the same clk, before any edge.
REQ-035 TESTPAT_EN defined, pattern_en=1 -> rgb_out=00 for x 0..63, 03 for x 64..127, FF for x 448..511; 00 in blanking.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: pixel-clock divider, x/y raster counters and registered sync/blank/colour decode
//   clk         in   system clock, all state changes on its rising edge
//   reset       in   asynchronous active-low reset
//   rgb_in      in   8-bit colour for the current x,y from the renderer
//   pattern_en  in   selects the built-in colour-bar pattern (only with VGA_TIMING_TESTPAT_EN)
//   x, y        out  11-bit pixel column / line counters
//   pixel_tick  out  one-clk strobe on the last divider count of each pixel
//   hsync/vsync out  active-low sync pulses
//   video_on    out  high while the displayed pixel is visible
//   rgb_out     out  colour to the DAC, 0 during blanking
//   frame_start out  one-clk pulse on the tick where x and y both wrap
// Optional feature macro: VGA_TIMING_TESTPAT_EN
module vga_timing #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rgb_in,
`ifdef VGA_TIMING_TESTPAT_EN
  input  logic        pattern_en,
`endif
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [7:0]  rgb_out,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic hs_q, hs_d, vs_q, vs_d, vo_q, vo_d;
  logic [7:0] rgb_q, rgb_d, pix;
  logic x_end, y_end, vis;
  always_comb begin
    pixel_tick  = div_q == DIV_W'(CLK_DIV - 1);
    x_end       = x_q == 11'(H_TOTAL - 1);
    y_end       = y_q == 11'(V_TOTAL - 1);
    frame_start = pixel_tick && x_end && y_end;
    div_d       = pixel_tick ? '0 : div_q + DIV_W'(1);
    x_d         = !pixel_tick ? x_q : x_end ? 11'd0 : x_q + 11'd1;
    y_d         = !(pixel_tick && x_end) ? y_q : y_end ? 11'd0 : y_q + 11'd1;
    vis         = (x_q < 11'(H_VISIBLE)) && (y_q < 11'(V_VISIBLE));
`ifdef VGA_TIMING_TESTPAT_EN
    // bar index x[8:6] expands to a 3-3-2 colour: {00,03,1C,1F,E0,E3,FC,FF}
    pix = pattern_en ? {{3{x_q[8]}}, {3{x_q[7]}}, {2{x_q[6]}}} : rgb_in;
`else
    pix = rgb_in;
`endif
    // decode uses the pre-increment position, so outputs trail x,y by one pixel
    hs_d  = pixel_tick ? !((x_q >= 11'(H_VISIBLE + H_FP)) && (x_q < 11'(H_VISIBLE + H_FP + H_SYNC))) : hs_q;
    vs_d  = pixel_tick ? !((y_q >= 11'(V_VISIBLE + V_FP)) && (y_q < 11'(V_VISIBLE + V_FP + V_SYNC))) : vs_q;
    vo_d  = pixel_tick ? vis : vo_q;
    rgb_d = pixel_tick ? (vis ? pix : 8'h00) : rgb_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      vo_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vo_q  <= vo_d;
      rgb_q <= rgb_d;
    end
  end
  assign x        = x_q;
  assign y        = y_q;
  assign hsync    = hs_q;
  assign vsync    = vs_q;
  assign video_on = vo_q;
  assign rgb_out  = rgb_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing on a reduced raster
module tb_vga_timing;
  localparam int CD = 3;
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam logic [7:0] BARS [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};
  typedef struct packed {logic hs; logic vs; logic vo; logic [7:0] rgb;} exp_t;
  localparam exp_t RST = '{1'b1, 1'b1, 1'b0, 8'h00};
  logic clk = 0, reset = 0;
  logic [7:0] rgb_in = 0;
  logic pe = 0;
`ifdef VGA_TIMING_TESTPAT_EN
  logic pattern_en;
  assign pattern_en = pe;
`endif
  logic [10:0] x, y;
  logic pixel_tick, hsync, vsync, video_on, frame_start;
  logic [7:0] rgb_out;
  int total = 0, bad = 0;
  exp_t q[$];
  exp_t cur = RST;
  bit run = 0;
  int c = 0, n = 0, dc = 0, pn = 0;
  always #5 clk = ~clk;
  vga_timing #(.CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in),
`ifdef VGA_TIMING_TESTPAT_EN
    .pattern_en(pattern_en),
`endif
    .x(x), .y(y), .pixel_tick(pixel_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .rgb_out(rgb_out), .frame_start(frame_start));
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t model(int p, logic [7:0] v, logic pat);
    int px, py;
    exp_t e;
    px = p % HT;
    py = (p / HT) % VT;
    e.vo = (px < HV) && (py < VV);
    e.hs = !((px >= HV + HF) && (px < HV + HF + HS));
    e.vs = !((py >= VV + VF) && (py < VV + VF + VS));
`ifdef VGA_TIMING_TESTPAT_EN
    e.rgb = !e.vo ? 8'h00 : pat ? BARS[(px / 64) % 8] : v;
`else
    e.rgb = !e.vo ? 8'h00 : v;
`endif
    return e;
  endfunction
  task automatic new_inputs();
    rgb_in = 8'($urandom);
`ifdef VGA_TIMING_TESTPAT_EN
    pe = 1'($urandom);
`endif
    q.push_back(model(pn, rgb_in, pe));
  endtask
  task automatic chk_rst(string tag);
    chk({tag, " x"}, x, 0);
    chk({tag, " y"}, y, 0);
    chk({tag, " pixel_tick"}, pixel_tick, 0);
    chk({tag, " frame_start"}, frame_start, 0);
    chk({tag, " hsync"}, hsync, 1);
    chk({tag, " vsync"}, vsync, 1);
    chk({tag, " video_on"}, video_on, 0);
    chk({tag, " rgb_out"}, rgb_out, 0);
  endtask
  task automatic start();
    @(posedge clk);
    #2;
    dc = 0;
    pn = 0;
    new_inputs();
    reset = 1;
    run = 1;
  endtask
  task automatic drive(int ncyc);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      dc++;
      if (dc % CD == 0) begin
        pn++;
        new_inputs();
      end
    end
  endtask
  // monitor: c = rising edges since release; a pixel is retired on every CD-th edge
  always @(negedge clk) begin
    if (!run) begin
      c = 0;
      n = 0;
      cur = RST;
    end else begin
      if (c > 0 && c % CD == 0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: got empty queue want entry at t=%0t", $time);
        end else cur = q.pop_front();
      end
      n = c / CD;
      chk("pixel_tick", pixel_tick, int'(c % CD == CD - 1));
      chk("x", x, n % HT);
      chk("y", y, (n / HT) % VT);
      chk("frame_start", frame_start, int'((c % CD == CD - 1) && (n % (HT * VT) == HT * VT - 1)));
      chk("hsync", hsync, cur.hs);
      chk("vsync", vsync, cur.vs);
      chk("video_on", video_on, cur.vo);
      chk("rgb_out", rgb_out, cur.rgb);
      c++;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 chk_rst("reset");
    start();
    drive(2 * HT * VT * CD + 7);
    #1;
    reset = 0;
    run = 0;
    #1 chk_rst("async reset");
    q.delete();
    repeat (4) @(posedge clk);
    #1 chk_rst("held reset");
    start();
    drive(HT * VT * CD + HT * CD * 3);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
